fp8_result_display: RTL and testbench

Downstream stage of the 8-bit floating-point adder in the TinyTapeout top.
- Takes each 8-bit adder result when it is marked valid and holds it.
- Shows the held byte on the single 7-segment output (uo_out[6:0], dp on uo_out[7]) as a timed sequence: high nibble, low nibble, blank gap.
- Replaces a static combinational decode, which cannot show a full byte on one digit.

---
 rtl/fp8_result_display.sv | 115 +++++++++++
 tb/tb_fp8_result_display.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fp8_result_display.sv
// Latches each valid FP8 adder result and shows it on one 7-segment digit
// as a timed sequence: high nibble, low nibble (with dp), blank gap.
module fp8_result_display #(
  parameter int unsigned HOLD_CYCLES = 12000000,
  parameter bit          LOOP        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] result_i,
  input  logic       result_valid_i,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = ($clog2(HOLD_CYCLES + 1) < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] LAST     = CW'(HOLD_CYCLES - 1);
  localparam logic [6:0]    SEG_DASH = 7'h40;

  typedef enum logic [1:0] {IDLE, HI, LO, GAP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    held, held_nx;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // A new strobe always wins, including over a GAP terminal count.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    held_nx  = held;
    if (result_valid_i) begin
      state_nx = HI;
      cnt_nx   = '0;
      held_nx  = result_i;
    end else if (state != IDLE) begin
      if (cnt == LAST) begin
        cnt_nx = '0;
        case (state)
          HI:      state_nx = LO;
          LO:      state_nx = GAP;
          GAP:     state_nx = LOOP ? HI : IDLE;
          default: state_nx = IDLE;
        endcase
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end
  end

  // Outputs are decoded from the next state so the digit appears in the
  // same cycle the FSM enters a phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      held   <= 8'h00;
      seg_o  <= SEG_DASH;
      dp_o   <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else if (!ena) begin
      seg_o  <= 7'h00;
      dp_o   <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      held   <= held_nx;
      busy_o <= (state_nx != IDLE);
      done_o <= (state_nx == GAP) && (cnt_nx == LAST);
      case (state_nx)
        HI: begin
          seg_o <= hex7(held_nx[7:4]);
          dp_o  <= 1'b0;
        end
        LO: begin
          seg_o <= hex7(held_nx[3:0]);
          dp_o  <= 1'b1;
        end
        GAP: begin
          seg_o <= 7'h00;
          dp_o  <= 1'b0;
        end
        default: begin
          seg_o <= SEG_DASH;
          dp_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_result_display.sv
// Drives three differently parameterised displays with shared stimulus and
// checks every output each cycle against a phase-position model.
module tb_fp8_result_display;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] result_i = 8'h00;
  logic       result_valid_i = 1'b0;

  logic [6:0] seg_w [3];
  logic       dp_w [3];
  logic       busy_w [3];
  logic       done_w [3];

  int assert_cnt = 0;
  int fail_cnt = 0;

  // Instance parameters: {HOLD_CYCLES, LOOP}
  int hold_a [3] = '{4, 2, 1};
  int loop_a [3] = '{1, 0, 1};

  logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: whether a sequence is active, enabled-cycle position within it, byte.
  bit         act [3];
  int         pos [3];
  logic [7:0] byt [3];
  bit         en_m;

  always #5 clk = ~clk;

  fp8_result_display #(.HOLD_CYCLES(4), .LOOP(1'b1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .result_i(result_i),
    .result_valid_i(result_valid_i), .seg_o(seg_w[0]), .dp_o(dp_w[0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]));

  fp8_result_display #(.HOLD_CYCLES(2), .LOOP(1'b0)) u_d1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .result_i(result_i),
    .result_valid_i(result_valid_i), .seg_o(seg_w[1]), .dp_o(dp_w[1]),
    .busy_o(busy_w[1]), .done_o(done_w[1]));

  fp8_result_display #(.HOLD_CYCLES(1), .LOOP(1'b1)) u_d2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .result_i(result_i),
    .result_valid_i(result_valid_i), .seg_o(seg_w[2]), .dp_o(dp_w[2]),
    .busy_o(busy_w[2]), .done_o(done_w[2]));

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      act[i] = 1'b0;
      pos[i] = 0;
      byt[i] = 8'h00;
    end
    en_m = 1'b1;
  endtask

  task automatic model_edge(input logic e, input logic v, input logic [7:0] b);
    en_m = e;
    if (e) begin
      for (int i = 0; i < 3; i++) begin
        if (v) begin
          act[i] = 1'b1;
          pos[i] = 0;
          byt[i] = b;
        end else if (act[i]) begin
          pos[i]++;
          if (pos[i] == 3 * hold_a[i]) begin
            pos[i] = 0;
            if (loop_a[i] == 0) act[i] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [6:0] got, input logic [6:0] exp);
    assert_cnt++;
    assert (got === exp) else begin
      fail_cnt++;
      $error("FAIL %s[%0d] t=%0t got %h expected %h", tag, i, $time, got, exp);
    end
  endtask

  task automatic check_all();
    logic [6:0] e_seg;
    logic       e_dp, e_done;
    int ph, w;
    for (int i = 0; i < 3; i++) begin
      ph = pos[i] / hold_a[i];
      w  = pos[i] % hold_a[i];
      e_seg = 7'h00; e_dp = 1'b0; e_done = 1'b0;
      if (en_m && !act[i]) e_seg = 7'h40;
      else if (en_m) begin
        case (ph)
          0: e_seg = dec[byt[i][7:4]];
          1: begin e_seg = dec[byt[i][3:0]]; e_dp = 1'b1; end
          default: e_done = (w == hold_a[i] - 1);
        endcase
      end
      chk("seg", i, seg_w[i], e_seg);
      chk("dp", i, {6'd0, dp_w[i]}, {6'd0, e_dp});
      chk("busy", i, {6'd0, busy_w[i]}, {6'd0, act[i]});
      chk("done", i, {6'd0, done_w[i]}, {6'd0, e_done});
    end
  endtask

  task automatic tick(input logic e, input logic v, input logic [7:0] b);
    @(negedge clk);
    ena = e;
    result_valid_i = v;
    result_i = b;
    @(posedge clk);
    model_edge(e, v, b);
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] dec_bytes [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    // Power-on reset and idle dash
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick(1'b1, 1'b0, 8'h00);

    // Basic sequence A7 with a full loop back to HI
    tick(1'b1, 1'b1, 8'hA7);
    repeat (16) tick(1'b1, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a clock period
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick(1'b1, 1'b0, 8'h00);

    // One-shot 3C (instance 1 returns to idle)
    tick(1'b1, 1'b1, 8'h3C);
    repeat (8) tick(1'b1, 1'b0, 8'h00);

    // Collision: new strobe during the last GAP cycle of the HOLD=4 instance
    tick(1'b1, 1'b1, 8'h12);
    repeat (11) tick(1'b1, 1'b0, 8'h00);
    tick(1'b1, 1'b1, 8'hF0);
    repeat (8) tick(1'b1, 1'b0, 8'h00);

    // ena gating inside the LO phase of 5E, with an ignored strobe
    tick(1'b1, 1'b1, 8'h5E);
    repeat (5) tick(1'b1, 1'b0, 8'h00);
    repeat (4) tick(1'b0, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h99);
    repeat (5) tick(1'b0, 1'b0, 8'h00);
    repeat (8) tick(1'b1, 1'b0, 8'h00);

    // Full decode table through all nibbles
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b1, dec_bytes[k]);
      repeat (2) tick(1'b1, 1'b0, 8'h00);
    end
    repeat (4) tick(1'b1, 1'b0, 8'h00);

    // Random strobes, bytes and enable drops
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(0, 9) != 0), ($urandom_range(0, 15) == 0), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
